generador_pixeles_demo: RTL and testbench
=========================================

// Module: generador_pixeles_demo
// PURPOSE
//  Pixel generator stage sitting directly downstream of the 640x480 VGA sync controller.
//  Consumes pixel_X, pixel_Y, video_on, p_tick and the registered syncs from the controller.
//  Produces one 8-bit RGB (RRRGGGBB) pixel per p_tick, plus syncs re-timed to match the RGB output.
//  Test patterns: colour bars, grid, and an animated bouncing square updated once per frame.
// PARAMETERS
//  HM    640  visible columns
//  VM    480  visible rows
//  SQ    32   square side in pixels
//  STEP  2    square displacement per frame per axis, in pixels (1..SQ)
// PORTS
//  CLK             in   1   system clock; the same clock that drives the sync controller
//  RESET           in   1   asynchronous, active-high reset
//  p_tick          in   1   pixel enable from the controller; all pixel-rate state advances only when p_tick=1
//  video_on        in   1   high inside the 640x480 visible area
//  pixel_X         in   10  current column, 0..799
//  pixel_Y         in   10  current row, 0..524
//  sincro_horiz_i  in   1   hsync from the controller
//  sincro_vert_i   in   1   vsync from the controller
//  sel_modo        in   2   pattern select: 00 bars, 01 square, 10 grid, 11 solid white
//  pausa           in   1   1 = freeze the square position
//  rgb             out  8   pixel colour, RRRGGGBB
//  sincro_horiz    out  1   hsync delayed to align with rgb
//  sincro_vert     out  1   vsync delayed to align with rgb
//  frame_tick      out  1   one-CLK pulse at the start of vertical blanking
// BEHAVIOUR
//  Reset (asynchronous)
//   - rgb=0, sincro_horiz=0, sincro_vert=0, frame_tick=0.
//   - modo=00. Square position sq_x=304, sq_y=224. Direction bits dir_x=+, dir_y=+.
//  Output pipeline
//   - rgb, sincro_horiz and sincro_vert are registered only on CLK edges where p_tick=1.
//   - Latency is exactly one pixel (2 CLK) from the inputs; hsync/vsync and rgb stay mutually aligned.
//   - When video_on=0 the registered rgb is 8'h00, regardless of mode.
//  Frame tick
//   - frame_tick=1 for one CLK when p_tick=1 && pixel_X==0 && pixel_Y==VM. Otherwise frame_tick=0.
//  Mode register
//   - modo loads sel_modo only on frame_tick; a mid-frame change takes effect from the next frame.
//  Patterns (registered value when video_on=1)
//   - 00 bars: 8 vertical bars of 80 px each. Bar k = pixel_X/80, with k=0..7, computed by range compares (no divider).
//     Bar colours, in order: FF, FC, 1F, 1C, E3, E0, 03, 00.
//   - 01 square: E0 (red) when sq_x<=pixel_X<sq_x+SQ and sq_y<=pixel_Y<sq_y+SQ; else 03 (blue).
//   - 10 grid: FF where pixel_X[4:0]==0, pixel_Y[4:0]==0, pixel_X==HM-1 or pixel_Y==VM-1; else 00.
//   - 11 solid: FF.
//  Square motion FSM (per axis; x shown, y identical using VM)
//   - States: MOVER_POS and MOVER_NEG. Evaluated only on frame_tick with pausa=0.
//   - MOVER_POS: if sq_x+SQ+STEP > HM then sq_x=HM-SQ and go to MOVER_NEG; else sq_x += STEP.
//   - MOVER_NEG: if sq_x < STEP then sq_x=0 and go to MOVER_POS; else sq_x -= STEP.
//   - Position and direction update in all modes, so the animation continues while hidden.
//   - pausa=1 on frame_tick: position and direction hold; modo still loads.
//   - All position arithmetic is 10-bit unsigned; the compares above never wrap.
//  Position stability
//   - Position never changes during the visible area, so the square shows no tearing.
//  Reset mid-frame
//   - All state returns to reset values immediately.
//   - Outputs resume with the next p_tick after RESET falls.
// TESTING
//  1. Reset, sel_modo=00, run 1 frame: row 10 rgb at x=0,79,80,639 -> FF,FF,FC,00; blanking rgb=00.
//  2. Sync alignment: sincro_horiz output rises exactly 2 CLK after sincro_horiz_i; rgb for pixel_X=0 appears on that same 2-CLK delay.
//  3. sel_modo=01, pausa=0: after 1 frame_tick sq=(306,226); pixel (306,226)=E0, pixel (305,226)=03.
//  4. Bounce: force sq_x=607 with dir +: next frame sq_x=608 and dir -; following frame sq_x=606. Same at 0 edge: sq_x=1, dir - -> 0, dir +.
//  5. pausa=1 across 3 frame_ticks -> sq unchanged. sel_modo changed mid-frame -> modo changes only at the next frame_tick.
//  6. Assert RESET at pixel (300,200) for 3 CLK -> rgb/syncs=0 immediately; sq=(304,224), modo=00 after release.

Source files
------------

// File: rtl/generador_pixeles_demo.sv
// ----------------------------------------------------------------------------
// generador_pixeles_demo
//
// Pixel generator placed right after the 640x480 VGA sync controller. It turns
// the controller's pixel coordinates into one RRRGGGBB colour per p_tick and
// re-times the syncs so they leave together with the colour. The test patterns
// are colour bars, a grid, solid white and a square that bounces around the
// screen, moving once per frame.
//
// Ports
//   CLK             system clock, shared with the sync controller
//   RESET           asynchronous, active-high reset
//   p_tick          pixel enable; pixel-rate state only moves when it is high
//   video_on        high inside the visible area
//   pixel_X/Y       current column (0..799) / row (0..524)
//   sincro_horiz_i  hsync from the controller
//   sincro_vert_i   vsync from the controller
//   sel_modo        pattern select: 00 bars, 01 square, 10 grid, 11 white
//   pausa           1 freezes the square
//   rgb             pixel colour, one pixel behind the inputs
//   sincro_horiz    hsync aligned with rgb
//   sincro_vert     vsync aligned with rgb
//   frame_tick      one-CLK pulse at the start of vertical blanking
// ----------------------------------------------------------------------------
module generador_pixeles_demo #(
    parameter int unsigned HM   = 640,
    parameter int unsigned VM   = 480,
    parameter int unsigned SQ   = 32,
    parameter int unsigned STEP = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_X,
    input  logic [9:0] pixel_Y,
    input  logic       sincro_horiz_i,
    input  logic       sincro_vert_i,
    input  logic [1:0] sel_modo,
    input  logic       pausa,
    output logic [7:0] rgb,
    output logic       sincro_horiz,
    output logic       sincro_vert,
    output logic       frame_tick
);

    localparam logic [9:0] HM_W   = 10'(HM);
    localparam logic [9:0] VM_W   = 10'(VM);
    localparam logic [9:0] SQ_W   = 10'(SQ);
    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam int unsigned BAR_W = HM / 8;

    // Bar colours, bar 0 in the top byte.
    localparam logic [63:0] COLORES = {8'hFF, 8'hFC, 8'h1F, 8'h1C,
                                       8'hE3, 8'hE0, 8'h03, 8'h00};

    localparam logic [0:0] MOVER_POS = 1'b0;
    localparam logic [0:0] MOVER_NEG = 1'b1;

    logic [1:0] modo;
    logic [9:0] sq_x, sq_y;
    logic [0:0] dir_x, dir_y;

    logic [7:0] rgb_p0, rgb_p1;
    logic       vld_p0;
    logic       hs_p1, vs_p1;
    logic       en_cuadro, en_rejilla;

    // Bar index found by comparing against the bar boundaries; the loop walks
    // downward so the narrowest matching boundary wins.
    function automatic logic [7:0] color_barra(input logic [9:0] x);
        logic [7:0] c;
        c = COLORES[7:0];
        for (int k = 6; k >= 0; k--) begin
            if (x < 10'((k + 1) * BAR_W))
                c = COLORES[63 - 8 * k -: 8];
        end
        return c;
    endfunction

    // One frame of motion along one axis; returns {new direction, new position}.
    function automatic logic [10:0] mover(input logic [0:0] dir,
                                          input logic [9:0] pos,
                                          input logic [9:0] extent);
        logic [9:0] lim;
        lim = extent - SQ_W;
        if (dir == MOVER_POS) begin
            if (pos + SQ_W + STEP_W > extent)
                return {MOVER_NEG, lim};
            else
                return {MOVER_POS, pos + STEP_W};
        end else begin
            if (pos < STEP_W)
                return {MOVER_POS, 10'd0};
            else
                return {MOVER_NEG, pos - STEP_W};
        end
    endfunction

    assign en_cuadro  = (pixel_X >= sq_x) && (pixel_X < sq_x + SQ_W) &&
                        (pixel_Y >= sq_y) && (pixel_Y < sq_y + SQ_W);
    assign en_rejilla = (pixel_X[4:0] == 5'd0) || (pixel_Y[4:0] == 5'd0) ||
                        (pixel_X == HM_W - 10'd1) || (pixel_Y == VM_W - 10'd1);

    // ---- stage p0: colour from the current coordinates ----
    always_comb begin
        vld_p0 = video_on;
        case (modo)
            2'b00:   rgb_p0 = color_barra(pixel_X);
            2'b01:   rgb_p0 = en_cuadro ? 8'hE0 : 8'h03;
            2'b10:   rgb_p0 = en_rejilla ? 8'hFF : 8'h00;
            default: rgb_p0 = 8'hFF;
        endcase
    end

    // ---- stage p1: registered pixel and syncs, plus once-per-frame state ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rgb_p1     <= 8'h00;
            hs_p1      <= 1'b0;
            vs_p1      <= 1'b0;
            frame_tick <= 1'b0;
            modo       <= 2'b00;
            sq_x       <= 10'((HM - SQ) / 2);
            sq_y       <= 10'((VM - SQ) / 2);
            dir_x      <= MOVER_POS;
            dir_y      <= MOVER_POS;
        end else begin
            frame_tick <= p_tick && (pixel_X == 10'd0) && (pixel_Y == VM_W);
            if (p_tick) begin
                rgb_p1 <= vld_p0 ? rgb_p0 : 8'h00;
                hs_p1  <= sincro_horiz_i;
                vs_p1  <= sincro_vert_i;
            end
            // frame_tick fires on row VM, outside the visible area, so the
            // square never moves while it is being drawn.
            if (frame_tick) begin
                modo <= sel_modo;
                if (!pausa) begin
                    {dir_x, sq_x} <= mover(dir_x, sq_x, HM_W);
                    {dir_y, sq_y} <= mover(dir_y, sq_y, VM_W);
                end
            end
        end
    end

    assign rgb          = rgb_p1;
    assign sincro_horiz = hs_p1;
    assign sincro_vert  = vs_p1;

endmodule

// File: tb/tb_generador_pixeles_demo.sv
// ----------------------------------------------------------------------------
// tb_generador_pixeles_demo
//
// Directed bench for generador_pixeles_demo. Coordinates are driven directly
// (no sync controller), one pixel per two CLK with p_tick high on the first.
// Outputs are sampled on the falling edge. Square positions come from a small
// behavioural model plus hand-worked bounce points.
// ----------------------------------------------------------------------------
module tb_generador_pixeles_demo;

    localparam int HM   = 640;
    localparam int VM   = 480;
    localparam int SQ   = 32;
    localparam int STEP = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       p_tick;
    logic       video_on;
    logic [9:0] pixel_X, pixel_Y;
    logic       sh_i, sv_i;
    logic [1:0] sel_modo;
    logic       pausa;
    logic [7:0] rgb;
    logic       sincro_horiz, sincro_vert, frame_tick;

    int n_vec = 0;
    int n_err = 0;

    // square model
    int mx, my;
    bit mdx, mdy;   // 0 = moving toward larger coordinates

    generador_pixeles_demo #(.HM(HM), .VM(VM), .SQ(SQ), .STEP(STEP)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .p_tick        (p_tick),
        .video_on      (video_on),
        .pixel_X       (pixel_X),
        .pixel_Y       (pixel_Y),
        .sincro_horiz_i(sh_i),
        .sincro_vert_i (sv_i),
        .sel_modo      (sel_modo),
        .pausa         (pausa),
        .rgb           (rgb),
        .sincro_horiz  (sincro_horiz),
        .sincro_vert   (sincro_vert),
        .frame_tick    (frame_tick)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    // One pixel: p_tick high across one rising edge, outputs valid afterwards.
    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic von, input logic h, input logic v);
        @(negedge CLK);
        pixel_X = x; pixel_Y = y; video_on = von; sh_i = h; sv_i = v;
        p_tick = 1'b1;
        @(negedge CLK);
        p_tick = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [7:0] exp);
        pix(10'(x), 10'(y), 1'b1, 1'b0, 1'b0);
        chk(tag, rgb, exp);
    endtask

    task automatic model_step();
        if (!mdx) begin
            if (mx + STEP > HM - SQ) begin mx = HM - SQ; mdx = 1; end
            else mx = mx + STEP;
        end else begin
            if (mx < STEP) begin mx = 0; mdx = 0; end
            else mx = mx - STEP;
        end
        if (!mdy) begin
            if (my + STEP > VM - SQ) begin my = VM - SQ; mdy = 1; end
            else my = my + STEP;
        end else begin
            if (my < STEP) begin my = 0; mdy = 0; end
            else my = my - STEP;
        end
    endtask

    // Pulse a frame start and let the update edge pass.
    task automatic frame();
        pix(10'd0, 10'(VM), 1'b0, 1'b0, 1'b1);
        chk("frame_tick", {7'b0, frame_tick}, 8'h01);
        @(negedge CLK);
        chk("frame_tick_1clk", {7'b0, frame_tick}, 8'h00);
        if (!pausa) model_step();
    endtask

    task automatic chk_sq();
        probe("sq_corner", mx, my, 8'hE0);
        probe("sq_far", mx + SQ - 1, my + SQ - 1, 8'hE0);
        if (mx > 0) probe("sq_left", mx - 1, my, 8'h03);
        else        probe("sq_right", mx + SQ, my, 8'h03);
        if (my > 0) probe("sq_above", mx, my - 1, 8'h03);
        else        probe("sq_below", mx, my + SQ, 8'h03);
    endtask

    initial begin
        RESET = 1'b1; p_tick = 1'b0; video_on = 1'b0;
        pixel_X = '0; pixel_Y = '0; sh_i = 1'b0; sv_i = 1'b0;
        sel_modo = 2'b00; pausa = 1'b0;

        // Reset state, even with active inputs
        @(negedge CLK);
        p_tick = 1'b1; video_on = 1'b1; sh_i = 1'b1; sv_i = 1'b1;
        @(negedge CLK);
        chk("rst_rgb", rgb, 8'h00);
        chk("rst_hs", {7'b0, sincro_horiz}, 8'h00);
        chk("rst_vs", {7'b0, sincro_vert}, 8'h00);
        chk("rst_ft", {7'b0, frame_tick}, 8'h00);
        p_tick = 1'b0; sh_i = 1'b0; sv_i = 1'b0;
        RESET = 1'b0;

        // Colour bars on row 10
        probe("bar_x0", 0, 10, 8'hFF);
        probe("bar_x79", 79, 10, 8'hFF);
        probe("bar_x80", 80, 10, 8'hFC);
        probe("bar_x160", 160, 10, 8'h1F);
        probe("bar_x319", 319, 10, 8'h1C);
        probe("bar_x320", 320, 10, 8'hE3);
        probe("bar_x400", 400, 10, 8'hE0);
        probe("bar_x559", 559, 10, 8'h03);
        probe("bar_x560", 560, 10, 8'h00);
        probe("bar_x639", 639, 10, 8'h00);
        pix(10'd40, 10'd10, 1'b0, 1'b0, 1'b0);
        chk("blank_rgb", rgb, 8'h00);

        // Sync alignment: input rises, output follows two CLK later with rgb
        pix(10'd0, 10'd10, 1'b1, 1'b0, 1'b0);
        chk("align_pre_rgb", rgb, 8'hFF);
        @(negedge CLK);
        sh_i = 1'b1; pixel_X = 10'd80;
        @(negedge CLK);
        chk("hs_after_1clk", {7'b0, sincro_horiz}, 8'h00);
        chk("rgb_after_1clk", rgb, 8'hFF);
        p_tick = 1'b1;
        @(negedge CLK);
        p_tick = 1'b0;
        chk("hs_after_2clk", {7'b0, sincro_horiz}, 8'h01);
        chk("rgb_after_2clk", rgb, 8'hFC);
        chk("vs_still_low", {7'b0, sincro_vert}, 8'h00);
        sv_i = 1'b1; sh_i = 1'b0; pixel_X = 10'd160;
        @(negedge CLK);
        chk("vs_after_1clk", {7'b0, sincro_vert}, 8'h00);
        p_tick = 1'b1;
        @(negedge CLK);
        p_tick = 1'b0;
        chk("vs_after_2clk", {7'b0, sincro_vert}, 8'h01);
        chk("hs_fall_2clk", {7'b0, sincro_horiz}, 8'h00);
        chk("rgb_vs_align", rgb, 8'h1F);

        // Square mode, first frame
        mx = (HM - SQ) / 2; my = (VM - SQ) / 2; mdx = 0; mdy = 0;
        sel_modo = 2'b01;
        probe("modo_not_yet", 0, 10, 8'hFF);
        frame();
        probe("sq_306_226", 306, 226, 8'hE0);
        probe("sq_305_226", 305, 226, 8'h03);
        probe("sq_306_225", 306, 225, 8'h03);
        probe("sq_337_257", 337, 257, 8'hE0);
        probe("sq_338_226", 338, 226, 8'h03);

        // Pause holds the square for 3 frames
        pausa = 1'b1;
        for (int i = 0; i < 3; i++) frame();
        probe("pause_306_226", 306, 226, 8'hE0);
        probe("pause_305_226", 305, 226, 8'h03);
        probe("pause_337_257", 337, 257, 8'hE0);

        // Mid-frame mode change waits for the next frame
        sel_modo = 2'b10;
        probe("mid_change_hold", 1, 1, 8'h03);
        frame();
        probe("grid_33_33", 33, 33, 8'h00);
        probe("grid_x32", 32, 5, 8'hFF);
        probe("grid_y64", 5, 64, 8'hFF);
        probe("grid_x639", 639, 7, 8'hFF);
        probe("grid_y479", 7, 479, 8'hFF);
        sel_modo = 2'b11;
        frame();
        probe("solid_33_33", 33, 33, 8'hFF);
        pix(10'd33, 10'd33, 1'b0, 1'b0, 1'b0);
        chk("solid_blank", rgb, 8'h00);
        sel_modo = 2'b01;
        frame();
        probe("back_sq_306_226", 306, 226, 8'hE0);

        // Bouncing: run past both edges on each axis
        pausa = 1'b0;
        for (int n = 1; n <= 460; n++) begin
            frame();
            chk_sq();
            if (n == 151) begin
                probe("bx151_in", 608, 370, 8'hE0);
                probe("bx151_out", 607, 370, 8'h03);
            end
            if (n == 153) begin
                probe("bx153_in", 606, 366, 8'hE0);
                probe("bx153_out", 605, 366, 8'h03);
            end
            if (n == 456) begin
                probe("bx456_in", 0, 238, 8'hE0);
                probe("bx456_right", 32, 238, 8'h03);
                probe("bx456_above", 0, 237, 8'h03);
            end
            if (n == 458) begin
                probe("bx458_in", 2, 242, 8'hE0);
                probe("bx458_out", 1, 242, 8'h03);
            end
        end

        // Reset in the middle of a frame
        pix(10'd300, 10'd200, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_hs", {7'b0, sincro_horiz}, 8'h01);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("midrst_rgb", rgb, 8'h00);
        chk("midrst_hs", {7'b0, sincro_horiz}, 8'h00);
        chk("midrst_vs", {7'b0, sincro_vert}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            p_tick = ~p_tick;
        end
        chk("midrst_hold_rgb", rgb, 8'h00);
        p_tick = 1'b0;
        RESET = 1'b0;
        sh_i = 1'b0; sv_i = 1'b0;
        mx = (HM - SQ) / 2; my = (VM - SQ) / 2; mdx = 0; mdy = 0;
        probe("rst_modo_bars", 300, 200, 8'h1C);
        pausa = 1'b1;
        frame();
        probe("rst_sq_304_224", 304, 224, 8'hE0);
        probe("rst_sq_303_224", 303, 224, 8'h03);
        probe("rst_sq_304_223", 304, 223, 8'h03);
        probe("rst_sq_335_255", 335, 255, 8'hE0);
        probe("rst_sq_336_255", 336, 255, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
